spi_slave_responder: RTL and testbench

- SPI mode-0 target (responder), the far end of the SoC's SPI master link (sclk, ss, mosi, miso).
- Used in FPGA test fixtures and co-processor designs where another chip masters the bus.
- Oversamples the SPI pins in the system clock domain and shifts MOSI bytes into an RX stream.
- Shifts bytes from a TX stream out on MISO; each interface is a byte-wide valid/ready handshake.

---
 rtl/spi_slave_responder_pkg.sv | 17 +
 rtl/spi_slave_responder_if.sv | 25 ++
 rtl/spi_slave_responder_sync.sv | 23 ++
 rtl/spi_slave_responder.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_responder_pkg.sv
// Shared types and defaults for the SPI mode-0 responder.
// Build option SPI_SLAVE_RX_FIFO_EN swaps the RX holding register for a FIFO.
package spi_slave_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int IDLE_WORD_DEF  = 'hFF;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Bit counter is one bit wider than needed to index a word.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/spi_slave_responder_if.sv
// Byte-stream side of the responder: RX words out, TX words in, valid/ready each.
interface spi_slave_responder_if
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_payload;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_payload;

  modport slave (
    output rx_valid, rx_payload, tx_ready,
    input  rx_ready, tx_valid, tx_payload
  );

  modport master (
    input  rx_valid, rx_payload, tx_ready,
    output rx_ready, tx_valid, tx_payload
  );

endinterface

// File: rtl/spi_slave_responder_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin; resets to 0.
module spi_slave_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder oversampling sclk/ss/mosi in io_clock; MOSI words to RX stream, TX stream to MISO.
// SPI_SLAVE_RX_FIFO_EN selects an RX_FIFO_DEPTH-entry RX FIFO instead of a single holding register.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int                    SYNC_STAGES   = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DATA_WIDTH'(IDLE_WORD_DEF),
  parameter int                    RX_FIFO_DEPTH = 4
) (
  input  logic io_clock,
  input  logic io_reset_n,
  input  logic io_spi_sclk,
  input  logic io_spi_ss,
  input  logic io_spi_mosi,
  output logic io_spi_miso,
  output logic io_spi_miso_oe,
  spi_slave_responder_if.slave io,
  output logic io_busy,
  output logic io_overrun,
  output logic io_underrun,
  input  logic io_flags_clear
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic sclk_s, ss_s, mosi_s;
  logic sclk_q, ss_q;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  // ss chain resets to 0 so a select held low across reset is not seen as a new falling edge.
  spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(io_clock), .rst_n(io_reset_n), .d(io_spi_sclk), .q(sclk_s));
  spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_ss   (.clk(io_clock), .rst_n(io_reset_n), .d(io_spi_ss),   .q(ss_s));
  spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(io_clock), .rst_n(io_reset_n), .d(io_spi_mosi), .q(mosi_s));

  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      sclk_q <= 1'b0;
      ss_q   <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      ss_q   <= ss_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = ~ss_s & ss_q;
  assign ss_rise   = ss_s & ~ss_q;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   tx_sr, tx_sr_n, load_word;
  logic [DATA_WIDTH-2:0]   rx_sr, rx_sr_n;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    tx_load, word_done;
  logic                    overrun_set, underrun_set;

  assign rx_word = {rx_sr, mosi_s};

  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      state <= IDLE;
      tx_sr <= '1;
      rx_sr <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      tx_sr <= tx_sr_n;
      rx_sr <= rx_sr_n;
      cnt   <= cnt_n;
    end
  end

  // A falling edge with the counter at 0 follows a completed word, so it reloads instead of shifting.
  always_comb begin
    state_n   = state;
    tx_sr_n   = tx_sr;
    rx_sr_n   = rx_sr;
    cnt_n     = cnt;
    tx_load   = 1'b0;
    word_done = 1'b0;
    load_word = io.tx_valid ? io.tx_payload : IDLE_WORD;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          tx_load = 1'b1;
          tx_sr_n = load_word;
          rx_sr_n = '0;
          cnt_n   = '0;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          tx_sr_n = '1;
          rx_sr_n = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (sclk_rise) begin
          rx_sr_n = (DATA_WIDTH-1)'({rx_sr, mosi_s});
          if (cnt == LAST_BIT) begin
            word_done = 1'b1;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (sclk_fall) begin
          if (cnt == '0) begin
            tx_load = 1'b1;
            tx_sr_n = load_word;
          end else begin
            tx_sr_n = {tx_sr[DATA_WIDTH-2:0], 1'b1};
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign io_spi_miso    = tx_sr[DATA_WIDTH-1];
  assign io_spi_miso_oe = (state == ACTIVE);
  assign io_busy        = (state == ACTIVE);
  assign io.tx_ready    = tx_load;
  assign underrun_set   = tx_load & ~io.tx_valid;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RX_FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, pop, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & io.rx_ready;
  assign push  = word_done & (~full | pop);
  assign overrun_set = word_done & full & ~pop;

  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= rx_word;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign io.rx_valid   = ~empty;
  assign io.rx_payload = mem[rd_ptr[AW-1:0]];
`else
  logic                  rx_valid_r;
  logic [DATA_WIDTH-1:0] rx_hold;
  logic                  pop;
  logic                  unused_fifo_cfg;

  assign unused_fifo_cfg = (RX_FIFO_DEPTH == 0);
  assign pop             = rx_valid_r & io.rx_ready;
  assign overrun_set     = word_done & rx_valid_r & ~pop;

  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      rx_valid_r <= 1'b0;
      rx_hold    <= '0;
    end else if (word_done && (!rx_valid_r || pop)) begin
      rx_valid_r <= 1'b1;
      rx_hold    <= rx_word;
    end else if (pop) begin
      rx_valid_r <= 1'b0;
    end
  end

  assign io.rx_valid   = rx_valid_r;
  assign io.rx_payload = rx_hold;
`endif

  // A set event in the same cycle as io_flags_clear wins.
  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      io_overrun  <= 1'b0;
      io_underrun <= 1'b0;
    end else begin
      if (overrun_set)         io_overrun <= 1'b1;
      else if (io_flags_clear) io_overrun <= 1'b0;
      if (underrun_set)        io_underrun <= 1'b1;
      else if (io_flags_clear) io_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: io_clock is 16x sclk; expectations follow SPI_SLAVE_RX_FIFO_EN.
module tb_spi_slave_responder;

  localparam int HALF_SCLK = 80;
`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic ss = 1'b1;
  logic mosi = 1'b0;
  logic flags_clear = 1'b0;
  logic miso, miso_oe, busy, overrun, underrun;

  spi_slave_responder_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_responder #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF), .RX_FIFO_DEPTH(4)
  ) dut (
    .io_clock(clk), .io_reset_n(rst_n),
    .io_spi_sclk(sclk), .io_spi_ss(ss), .io_spi_mosi(mosi),
    .io_spi_miso(miso), .io_spi_miso_oe(miso_oe),
    .io(bus),
    .io_busy(busy), .io_overrun(overrun), .io_underrun(underrun),
    .io_flags_clear(flags_clear)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int tx_pulses = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (bus.tx_ready) tx_pulses++;
    if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_payload);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    step(1);
    flags_clear = 1'b1;
    step(1);
    flags_clear = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss = 1'b0;
  endtask

  task automatic ss_high();
    #HALF_SCLK;
    ss = 1'b1;
    step(12);
  endtask

  // Master: drive MOSI on the falling edge, sample MISO just before the rising edge.
  task automatic spi_bits(input logic [7:0] out, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = out[7-i];
      #HALF_SCLK;
      got[7-i] = miso;
      sclk = 1'b1;
      #HALF_SCLK;
      sclk = 1'b0;
    end
  endtask

  task automatic pop_rx(output logic [7:0] d);
    if (rx_q.size() > 0) d = rx_q.pop_front();
    else d = 'x;
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic       tx_vld;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    logic       exp_under;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[5];
    logic [7:0] got, rxd;
    logic [7:0] exp_q[$];
    int p0;
    logic seen;

    tv[0] = '{8'h3C, 8'hA5, 1'b1, 8'hA5, 8'h3C, 1'b0};
    tv[1] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 8'h00, 1'b0};
    tv[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0};
    tv[3] = '{8'h81, 8'h7E, 1'b1, 8'h7E, 8'h81, 1'b0};
    tv[4] = '{8'h5A, 8'h00, 1'b0, 8'hFF, 8'h5A, 1'b1};

    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_payload = 8'h00;
    step(4);
    rst_n = 1'b1;

    check("reset_miso", miso, 1);
    check("reset_miso_oe", miso_oe, 0);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_payload", bus.rx_payload, 0);
    check("reset_tx_ready", bus.tx_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_underrun", underrun, 0);

    // Each single-word select gives two loads: the word itself and the look-ahead
    // load on the closing falling edge, which is lost when ss rises.
    for (int v = 0; v < 5; v++) begin
      pulse_clear();
      bus.tx_payload = tv[v].tx;
      bus.tx_valid = tv[v].tx_vld;
      bus.rx_ready = 1'b1;
      p0 = tx_pulses;
      ss_low();
      spi_bits(tv[v].mosi, 8, got);
      ss_high();
      pop_rx(rxd);
      check($sformatf("vec%0d_miso", v), got, tv[v].exp_miso);
      check($sformatf("vec%0d_rx", v), rxd, tv[v].exp_rx);
      check($sformatf("vec%0d_rx_extra", v), rx_q.size(), 0);
      check($sformatf("vec%0d_underrun", v), underrun, tv[v].exp_under);
      check($sformatf("vec%0d_overrun", v), overrun, 0);
      check($sformatf("vec%0d_tx_pulses", v), tx_pulses - p0, 2);
    end
    pulse_clear();
    check("underrun_cleared", underrun, 0);

    // Three back-to-back words with the consumer stalled.
    bus.tx_payload = 8'hA5;
    bus.tx_valid = 1'b1;
    bus.rx_ready = 1'b0;
    ss_low();
    spi_bits(8'h01, 8, got);
    check("stall_w1_miso", got, 8'hA5);
    check("stall_w1_rx_valid", bus.rx_valid, 1);
    check("stall_w1_rx_payload", bus.rx_payload, 8'h01);
    check("stall_w1_overrun", overrun, 0);
    spi_bits(8'h02, 8, got);
    check("stall_w2_miso", got, 8'hA5);
    check("stall_w2_overrun", overrun, (DEPTH == 1) ? 1 : 0);
    spi_bits(8'h03, 8, got);
    check("stall_w3_miso", got, 8'hA5);
    check("stall_w3_rx_payload", bus.rx_payload, 8'h01);
    check("stall_w3_overrun", overrun, (DEPTH == 1) ? 1 : 0);
    ss_high();
    if (DEPTH > 1) exp_q = '{8'h01, 8'h02, 8'h03};
    else exp_q = '{8'h01};
    bus.rx_ready = 1'b1;
    step(10);
    bus.rx_ready = 1'b0;
    check("stall_drain_count", rx_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      pop_rx(rxd);
      check($sformatf("stall_drain_%0d", i), rxd, exp_q[i]);
    end
    pulse_clear();
    check("overrun_cleared", overrun, 0);

    // Fill RX, then overflow while flags_clear is held: the set must win.
    ss_low();
    for (int k = 0; k < DEPTH; k++) spi_bits(8'h10 + 8'(k), 8, got);
    step(1);
    flags_clear = 1'b1;
    seen = 1'b0;
    fork
      spi_bits(8'h2F, 8, got);
      begin
        for (int c = 0; c < 400 && !seen; c++) begin
          @(negedge clk);
          if (overrun) begin
            #1 flags_clear = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    flags_clear = 1'b0;
    check("set_beats_clear_seen", seen, 1);
    step(3);
    check("set_beats_clear_overrun", overrun, 1);
    ss_high();
    bus.rx_ready = 1'b1;
    step(2 * DEPTH + 4);
    rx_q.delete();
    pulse_clear();

    // Abort after five sclk cycles, then a clean word.
    ss_low();
    spi_bits(8'hFF, 5, got);
    check("abort_oe_mid", miso_oe, 1);
    check("abort_busy_mid", busy, 1);
    ss_high();
    check("abort_oe_after", miso_oe, 0);
    check("abort_busy_after", busy, 0);
    check("abort_miso_after", miso, 1);
    check("abort_no_rx", rx_q.size(), 0);
    ss_low();
    spi_bits(8'h5A, 8, got);
    ss_high();
    check("abort_next_miso", got, 8'hA5);
    check("abort_next_count", rx_q.size(), 1);
    pop_rx(rxd);
    check("abort_next_rx", rxd, 8'h5A);

    // Reset for one cycle mid-word.
    ss_low();
    spi_bits(8'hF0, 4, got);
    check("rst_busy_before", busy, 1);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("rst_miso", miso, 1);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_payload", bus.rx_payload, 0);
    check("rst_tx_ready", bus.tx_ready, 0);
    check("rst_overrun", overrun, 0);
    check("rst_underrun", underrun, 0);
    spi_bits(8'h0F, 4, got);
    check("rst_ignored_oe", miso_oe, 0);
    check("rst_ignored_busy", busy, 0);
    ss_high();
    check("rst_no_rx", rx_q.size(), 0);
    ss_low();
    spi_bits(8'hC3, 8, got);
    ss_high();
    check("rst_next_miso", got, 8'hA5);
    check("rst_next_count", rx_q.size(), 1);
    pop_rx(rxd);
    check("rst_next_rx", rxd, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
